// File: rtl/iter_counter_if.sv
// Control/status bundle for iter_counter: manual opcodes, auto-sequence control,
// bounds and the registered count/status returned by the counter.
interface iter_counter_if #(
    parameter int unsigned W = 4
);
    logic [2:0]   opc_i;
    logic         start_i;
    logic         abort_i;
    logic         dir_i;
    logic         wrap_en_i;
    logic [W-1:0] lo_i;
    logic [W-1:0] hi_i;
    logic [W-1:0] step_i;
    logic [W-1:0] ld_i;
    logic [W-1:0] addr_o;
    logic         z_o;
    logic         busy_o;
    logic         done_o;
    logic         wrap_o;

    modport master (
        output opc_i, start_i, abort_i, dir_i, wrap_en_i, lo_i, hi_i, step_i, ld_i,
        input  addr_o, z_o, busy_o, done_o, wrap_o
    );

    modport slave (
        input  opc_i, start_i, abort_i, dir_i, wrap_en_i, lo_i, hi_i, step_i, ld_i,
        output addr_o, z_o, busy_o, done_o, wrap_o
    );
endinterface

// File: rtl/iter_counter.sv
// Bounded address counter: manual CLR/HOLD/INC/DEC/LOAD while idle, plus an
// auto sequence that walks lo..hi (or hi..lo) by step and reports done.
module iter_counter #(
    parameter int unsigned W = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    iter_counter_if.slave  bus
);
    localparam int unsigned WX = W + 1;

    localparam logic [2:0] OPC_CLR  = 3'd0;
    localparam logic [2:0] OPC_INC  = 3'd2;
    localparam logic [2:0] OPC_DEC  = 3'd3;
    localparam logic [2:0] OPC_LOAD = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  addr_q, addr_d;
    logic          wrap_q, wrap_d;
    logic          dir_q, dir_d;
    logic          busy_q, done_q;

    logic [WX-1:0] up_sum;
    logic [WX-1:0] dn_lim;
    logic          up_ovf;
    logic          dn_unf;
    logic [W-1:0]  dn_val;

    // One extra bit keeps the carry so bounds near the top of the range compare correctly.
    always_comb begin
        up_sum = WX'(addr_q) + WX'(bus.step_i);
        dn_lim = WX'(bus.lo_i) + WX'(bus.step_i);
        up_ovf = up_sum > WX'(bus.hi_i);
        dn_unf = WX'(addr_q) < dn_lim;
        dn_val = addr_q - bus.step_i;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wrap_d  = 1'b0;
        dir_d   = dir_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    addr_d  = bus.dir_i ? bus.hi_i : bus.lo_i;
                    dir_d   = bus.dir_i;
                    state_d = S_RUN;
                end else begin
                    case (bus.opc_i)
                        OPC_CLR:  addr_d = '0;
                        OPC_INC: begin
                            if (!up_ovf) begin
                                addr_d = up_sum[W-1:0];
                            end else if (bus.wrap_en_i) begin
                                addr_d = bus.lo_i;
                                wrap_d = 1'b1;
                            end else begin
                                addr_d = bus.hi_i;
                            end
                        end
                        OPC_DEC: begin
                            if (!dn_unf) begin
                                addr_d = dn_val;
                            end else if (bus.wrap_en_i) begin
                                addr_d = bus.hi_i;
                                wrap_d = 1'b1;
                            end else begin
                                addr_d = bus.lo_i;
                            end
                        end
                        OPC_LOAD: addr_d = bus.ld_i;
                        default:  addr_d = addr_q;
                    endcase
                end
            end
            S_RUN: begin
                // Auto stepping always saturates at the end bound; it never wraps.
                if (bus.abort_i) begin
                    state_d = S_IDLE;
                end else if (addr_q == (dir_q ? bus.lo_i : bus.hi_i)) begin
                    state_d = S_DONE;
                end else if (!dir_q) begin
                    addr_d = up_ovf ? bus.hi_i : up_sum[W-1:0];
                end else begin
                    addr_d = dn_unf ? bus.lo_i : dn_val;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wrap_q  <= 1'b0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wrap_q  <= wrap_d;
            dir_q   <= dir_d;
            busy_q  <= (state_d == S_RUN);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign bus.addr_o = addr_q;
    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;
    assign bus.wrap_o = wrap_q;
    assign bus.z_o    = (addr_q == bus.hi_i);
endmodule

// File: tb/tb_iter_counter.sv
// Directed and randomized checks of iter_counter against a cycle-level
// behavioural model computed with plain integer arithmetic.
module tb_iter_counter;
    localparam int unsigned W = 4;

    localparam logic [2:0] OPC_CLR  = 3'd0;
    localparam logic [2:0] OPC_HOLD = 3'd1;
    localparam logic [2:0] OPC_INC  = 3'd2;
    localparam logic [2:0] OPC_DEC  = 3'd3;
    localparam logic [2:0] OPC_LOAD = 3'd4;

    logic clk_i = 1'b0;
    logic rst_i;

    iter_counter_if #(.W(W)) bus ();

    iter_counter #(.W(W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Model: phase 0 idle, 1 running, 2 done
    int m_phase, m_addr, m_wrap, m_dir;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_addr  = 0;
        m_wrap  = 0;
        m_dir   = 0;
    endtask

    task automatic model_step();
        int lo, hi, st, fin;
        lo = int'(bus.lo_i);
        hi = int'(bus.hi_i);
        st = int'(bus.step_i);
        m_wrap = 0;
        if (m_phase == 0) begin
            if (bus.start_i) begin
                m_addr  = bus.dir_i ? hi : lo;
                m_dir   = int'(bus.dir_i);
                m_phase = 1;
            end else begin
                case (bus.opc_i)
                    OPC_CLR:  m_addr = 0;
                    OPC_INC: begin
                        if (m_addr + st <= hi) m_addr = m_addr + st;
                        else if (bus.wrap_en_i) begin m_addr = lo; m_wrap = 1; end
                        else m_addr = hi;
                    end
                    OPC_DEC: begin
                        if (m_addr >= lo + st) m_addr = m_addr - st;
                        else if (bus.wrap_en_i) begin m_addr = hi; m_wrap = 1; end
                        else m_addr = lo;
                    end
                    OPC_LOAD: m_addr = int'(bus.ld_i);
                    default:  ;
                endcase
            end
        end else if (m_phase == 1) begin
            fin = (m_dir != 0) ? lo : hi;
            if (bus.abort_i) m_phase = 0;
            else if (m_addr == fin) m_phase = 2;
            else if (m_dir == 0) m_addr = (m_addr + st > hi) ? hi : m_addr + st;
            else m_addr = (m_addr - st < lo) ? lo : m_addr - st;
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_addr"}, 32'(bus.addr_o), 32'(m_addr));
        chk({tag, "_busy"}, 32'(bus.busy_o), 32'(m_phase == 1));
        chk({tag, "_done"}, 32'(bus.done_o), 32'(m_phase == 2));
        chk({tag, "_wrap"}, 32'(bus.wrap_o), 32'(m_wrap));
        chk({tag, "_z"},    32'(bus.z_o),    32'(m_addr == int'(bus.hi_i)));
    endtask

    task automatic cyc(input string tag);
        model_step();
        @(posedge clk_i);
        #1;
        check_all(tag);
    endtask

    initial begin
        int a, b;
        rst_i         = 1'b1;
        bus.opc_i     = OPC_HOLD;
        bus.start_i   = 1'b0;
        bus.abort_i   = 1'b0;
        bus.dir_i     = 1'b0;
        bus.wrap_en_i = 1'b0;
        bus.lo_i      = '0;
        bus.hi_i      = '0;
        bus.step_i    = '0;
        bus.ld_i      = '0;
        model_reset();
        #1;
        check_all("reset");
        @(posedge clk_i);
        #4;
        rst_i = 1'b0;

        // Up sequence 2,5,8,9 then done; opcodes during RUN are ignored
        bus.lo_i = 4'd2; bus.hi_i = 4'd9; bus.step_i = 4'd3; bus.dir_i = 1'b0;
        bus.start_i = 1'b1;
        cyc("r028_s0"); chk("r028_a0", 32'(bus.addr_o), 32'd2);
        bus.start_i = 1'b0; bus.opc_i = OPC_CLR;
        cyc("r028_s1"); chk("r028_a1", 32'(bus.addr_o), 32'd5);
        cyc("r028_s2"); chk("r028_a2", 32'(bus.addr_o), 32'd8);
        cyc("r028_s3"); chk("r028_a3", 32'(bus.addr_o), 32'd9);
        chk("r028_z3", 32'(bus.z_o), 32'd1);
        chk("r028_busy3", 32'(bus.busy_o), 32'd1);
        cyc("r028_s4"); chk("r028_done", 32'(bus.done_o), 32'd1);
        chk("r028_a4", 32'(bus.addr_o), 32'd9);
        bus.opc_i = OPC_HOLD;
        cyc("r028_s5"); chk("r028_idle", 32'(bus.done_o), 32'd0);

        // Manual INC with wrap
        bus.lo_i = 4'd0; bus.hi_i = 4'd15; bus.step_i = 4'd1; bus.wrap_en_i = 1'b1;
        bus.opc_i = OPC_LOAD; bus.ld_i = 4'd14;
        cyc("r029_ld");
        bus.opc_i = OPC_INC;
        cyc("r029_i1"); chk("r029_z", 32'(bus.z_o), 32'd1);
        cyc("r029_i2"); chk("r029_wrap", 32'(bus.wrap_o), 32'd1);
        chk("r029_a", 32'(bus.addr_o), 32'd0);
        bus.opc_i = OPC_HOLD;
        cyc("r029_h");  chk("r029_wrap_off", 32'(bus.wrap_o), 32'd0);

        // Manual DEC with saturation
        bus.lo_i = 4'd3; bus.hi_i = 4'd12; bus.step_i = 4'd5; bus.wrap_en_i = 1'b0;
        bus.opc_i = OPC_LOAD; bus.ld_i = 4'd10;
        cyc("r030_ld");
        bus.opc_i = OPC_DEC;
        cyc("r030_d1"); chk("r030_a1", 32'(bus.addr_o), 32'd5);
        cyc("r030_d2"); chk("r030_a2", 32'(bus.addr_o), 32'd3);
        cyc("r030_d3"); chk("r030_a3", 32'(bus.addr_o), 32'd3);
        chk("r030_wrap", 32'(bus.wrap_o), 32'd0);
        bus.opc_i = OPC_HOLD;

        // Down sequence aborted at 5
        bus.lo_i = 4'd1; bus.hi_i = 4'd7; bus.step_i = 4'd2; bus.dir_i = 1'b1;
        bus.start_i = 1'b1;
        cyc("r031_s0"); chk("r031_a0", 32'(bus.addr_o), 32'd7);
        bus.start_i = 1'b0;
        cyc("r031_s1"); chk("r031_a1", 32'(bus.addr_o), 32'd5);
        bus.abort_i = 1'b1;
        cyc("r031_ab"); chk("r031_a2", 32'(bus.addr_o), 32'd5);
        chk("r031_busy", 32'(bus.busy_o), 32'd0);
        bus.abort_i = 1'b0;
        cyc("r031_p1"); chk("r031_done", 32'(bus.done_o), 32'd0);
        cyc("r031_p2");

        // start_i beats a same-cycle LOAD
        bus.lo_i = 4'd4; bus.hi_i = 4'd9; bus.dir_i = 1'b0; bus.step_i = 4'd1;
        bus.opc_i = OPC_LOAD; bus.ld_i = 4'd13; bus.start_i = 1'b1;
        cyc("r032_s");  chk("r032_a", 32'(bus.addr_o), 32'd4);
        chk("r032_busy", 32'(bus.busy_o), 32'd1);
        bus.start_i = 1'b0; bus.opc_i = OPC_HOLD; bus.abort_i = 1'b1;
        cyc("r032_ab");
        bus.abort_i = 1'b0;

        // Asynchronous reset in the middle of a run
        bus.lo_i = 4'd2; bus.hi_i = 4'd15; bus.step_i = 4'd3; bus.dir_i = 1'b0;
        bus.start_i = 1'b1;
        cyc("r033_s0");
        bus.start_i = 1'b0;
        cyc("r033_s1");
        cyc("r033_s2"); chk("r033_pre", 32'(bus.addr_o), 32'd8);
        #2;
        rst_i = 1'b1;
        #1;
        model_reset();
        check_all("r033_async");
        chk("r033_a", 32'(bus.addr_o), 32'd0);
        chk("r033_busy", 32'(bus.busy_o), 32'd0);
        #1;
        rst_i = 1'b0;
        cyc("r033_post");

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            bus.opc_i     = 3'($urandom_range(0, 7));
            bus.start_i   = ($urandom_range(0, 9) == 0);
            bus.abort_i   = ($urandom_range(0, 11) == 0);
            bus.dir_i     = 1'($urandom);
            bus.wrap_en_i = 1'($urandom);
            bus.ld_i      = W'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) begin
                a = int'($urandom_range(0, 15));
                b = int'($urandom_range(a, 15));
                bus.lo_i = W'(a);
                bus.hi_i = W'(b);
            end
            if ($urandom_range(0, 15) == 0) bus.step_i = '0;
            else bus.step_i = W'($urandom_range(1, 15));
            cyc("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/iter_counter.md
ITER_COUNTER -- requirements
Module: iter_counter

Interface
REQ-001 SHALL have parameter: W, default 4, counter/address width (W >= 2).
REQ-002 SHALL have ports: clk_i  in  1  rising-edge clock.
REQ-003 SHALL have ports: rst_i  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: opc_i  in  3  manual opcode, IDLE only: 0 CLR, 1 HOLD, 2 INC, 3 DEC, 4 LOAD, 5-7 HOLD.
REQ-005 SHALL have ports: start_i  in  1  launch auto sequence.
REQ-006 SHALL have ports: abort_i  in  1  terminate auto sequence.
REQ-007 SHALL have ports: dir_i  in  1  auto direction, 0 up (lo->hi), 1 down (hi->lo); sampled at start.
REQ-008 SHALL have ports: wrap_en_i  in  1  manual INC/DEC out-of-bound action, 1 wrap, 0 saturate.
REQ-009 SHALL have ports: lo_i, hi_i  in  W  inclusive bounds; caller SHALL hold lo_i <= hi_i.
REQ-010 SHALL have ports: step_i  in  W  increment magnitude.
REQ-011 SHALL have ports: ld_i  in  W  LOAD value.
REQ-012 SHALL have ports: addr_o  out  W  registered count.
REQ-013 SHALL have ports: z_o  out  1  combinational, addr_o == hi_i.
REQ-014 SHALL have ports: busy_o, done_o, wrap_o  out  1 each  registered status.

Function
REQ-015 SHALL implement FSM IDLE, RUN, DONE; busy_o = (state == RUN), done_o = (state == DONE).
REQ-016 Step arithmetic SHALL use W+1 bits: up overflow when addr + step > hi_i (carry included); down underflow when addr < lo_i + step (W+1-bit sum).
REQ-017 IDLE, no start_i: CLR -> addr 0; HOLD -> unchanged; LOAD -> ld_i, no clamping; INC uses up rule, DEC uses down rule, regardless of dir_i.
REQ-018 Manual INC/DEC out of bound: wrap_en_i=1 -> INC yields lo_i, DEC yields hi_i, wrap_o=1 for the following cycle; wrap_en_i=0 -> saturate to hi_i / lo_i, wrap_o=0.
REQ-019 wrap_o SHALL be a one-cycle pulse coincident with the wrapped addr_o value; 0 otherwise.
REQ-020 IDLE + start_i: addr <- lo_i (dir_i=0) or hi_i (dir_i=1); latch direction; -> RUN. start_i SHALL take priority over opc_i in the same cycle.
REQ-021 RUN: if addr == end bound (hi_i up, lo_i down) -> DONE, addr held; else step toward end, always saturating at end bound, never wrapping, wrap_o=0.
REQ-022 DONE SHALL last exactly one cycle, addr held, then -> IDLE.
REQ-023 abort_i in RUN or DONE SHALL -> IDLE next edge, addr held, done_o not asserted afterwards; abort_i in IDLE ignored.
REQ-024 start_i outside IDLE and opc_i outside IDLE SHALL be ignored.
REQ-025 step_i = 0 in RUN with addr != end SHALL hold addr (no hang protection; abort_i required).

Reset
REQ-026 rst_i SHALL immediately force state IDLE, addr_o 0, busy_o 0, done_o 0, wrap_o 0, latched direction 0, in any state including mid-RUN.
REQ-027 First active edge after rst_i release SHALL be processed normally.

Verification
REQ-028 W=4, lo=2 hi=9 step=3 dir=0, start pulse -> addr 2,5,8,9 with busy_o=1 for those 4 cycles, then done_o=1 one cycle (addr 9), then IDLE, z_o=1 while addr=9.
REQ-029 lo=0 hi=15 step=1 wrap_en=1, LOAD 14, INC, INC -> addr 15 (z_o=1), then 0 with wrap_o=1 one cycle.
REQ-030 lo=3 hi=12 step=5 wrap_en=0, LOAD 10, DEC x3 -> addr 5, 3, 3; wrap_o stays 0.
REQ-031 lo=1 hi=7 step=2 dir=1, start -> addr 7,5; abort_i at addr 5 -> IDLE, addr 5 held, busy_o 0, done_o never 1.
REQ-032 IDLE, start_i=1 with opc_i=LOAD ld=13 same cycle, lo=4 dir=0 -> addr 4, busy_o=1 (start wins).
REQ-033 rst_i asserted asynchronously mid-RUN at addr 8 -> addr_o 0, busy_o 0, done_o 0, wrap_o 0 immediately, before next clock edge.
